serial_adder: RTL and testbench
===============================

# serial_adder

Multi-cycle, parametrised adder built around the one-bit full-adder cell. It adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, LSB first, using a registered carry. Operands enter and results leave through valid/ready handshakes. It is the area-lean arithmetic engine for datapaths where a full-width ripple adder is too large.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per RUN cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous, active-low reset.
- START_VALID  in  1  operands valid.
- START_READY  out  1  block can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- C  in  1  carry-in.
- SUB  in  1  subtract mode; present only with SERIAL_ADDER_SUB_EN.
- SUM  out  WIDTH  result.
- CARRY  out  1  carry-out of the MSB.
- OVF  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- DONE_VALID  out  1  SUM/CARRY/OVF valid.
- DONE_READY  in  1  consumer accepts result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: START_READY=1. START_VALID=1 registers A, B, C (and SUB), clears the digit counter, and moves to RUN.
  - RUN: each cycle adds DIGIT bits of the operand registers plus the carry register. It writes those DIGIT bits of SUM and updates the carry.
  - RUN -> DONE when the counter reaches N-1. CARRY and OVF are registered on that same edge.
  - DONE: DONE_VALID=1, and outputs hold steady. DONE_VALID && DONE_READY returns the FSM to IDLE.
- Operands are sampled only on the accept edge. Changes to A, B, C or SUB during RUN or DONE are ignored.
- START_VALID in RUN or DONE is ignored. START_READY=0 there, and there is no bypass from DONE to RUN.
- Arithmetic is modulo 2^WIDTH. CARRY is the true (WIDTH+1)th bit.
- DIGIT=WIDTH is legal: single RUN cycle.
- Reset mid-operation: the operation is aborted with no result. State goes to IDLE and all registers clear.

## Timing
- Reset values (on the edge where RST_N=0 is sampled): state IDLE; SUM=0, CARRY=0, OVF=0, DONE_VALID=0. START_READY=0 while RST_N=0 and 1 on the first cycle after release.
- Latency: accept at edge k gives DONE_VALID=1 from edge k+N.
- DONE_VALID stays high until a handshake edge. START_READY rises one cycle after that edge.
- Throughput: one result per N+2 cycles with DONE_READY tied high.
- SUM bits for later digits are undefined during RUN. They are only meaningful while DONE_VALID=1.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - SUB port exists.
  - SUB=1 computes A - B by inverting registered B and forcing carry-in to 1. C is ignored.
  - CARRY=1 means no borrow. OVF is signed subtraction overflow.
  - SUB=0 gives normal addition.
- SERIAL_ADDER_SUB_EN undefined:
  - SUB port is absent, and the block is add-only.
  - No inversion logic is present.

## Test plan
- WIDTH=1, DIGIT=1, all 8 combinations of A, B, C. Each gives {CARRY,SUM} = A+B+C after a latency of 1 cycle, matching the full-adder truth table.
- WIDTH=8, DIGIT=1, A=0xFF, B=0x01, C=0. SUM=0x00, CARRY=1, OVF=0, with DONE_VALID exactly 8 cycles after accept. A=0x7F, B=0x01 gives SUM=0x80, CARRY=0, OVF=1.
- WIDTH=8, DIGIT=4, A=0x3C, B=0x55, C=1. SUM=0x92, CARRY=0, DONE_VALID 2 cycles after accept. Operands toggled during RUN must not change the result.
- Backpressure: hold DONE_READY=0 for 5 cycles. DONE_VALID and SUM stay stable, START_READY stays 0, and a pulsed START_VALID is not accepted. Release gives the handshake, then START_READY=1 next cycle.
- Reset mid-run: drive RST_N=0 on the 3rd RUN cycle. Next cycle SUM=0, CARRY=0, OVF=0, DONE_VALID=0. START_READY=1 the cycle after release, and a fresh add completes correctly.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, SUB=1: A=0x05, B=0x07 gives SUM=0xFE, CARRY=0, OVF=0. A=0x80, B=0x01 gives SUM=0x7F, CARRY=1, OVF=1.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit A + B + C, DIGIT bits per cycle, LSB first, valid/ready on both ends.
// Define SERIAL_ADDER_SUB_EN to add the SUB port (A - B via inverted B and forced carry-in).
`timescale 1ns/1ps
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START_VALID,
    output logic             START_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVF,
    output logic             DONE_VALID,
    input  logic             DONE_READY
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic             cy_r;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [DIGIT-1:0] a_d, b_d, s_d;
    logic [DIGIT:0]   cc;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_r;
`endif

    assign last = (cnt == CW'(N - 1));
    assign a_d  = a_r[cnt*DIGIT +: DIGIT];
`ifdef SERIAL_ADDER_SUB_EN
    assign b_d  = b_r[cnt*DIGIT +: DIGIT] ^ {DIGIT{sub_r}};
`else
    assign b_d  = b_r[cnt*DIGIT +: DIGIT];
`endif

    // Ripple of one-bit full-adder cells across the current digit.
    assign cc[0] = cy_r;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_d[i]   = a_d[i] ^ b_d[i] ^ cc[i];
        assign cc[i+1]  = (a_d[i] & b_d[i]) | (cc[i] & (a_d[i] ^ b_d[i]));
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            cy_r  <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            CARRY <= 1'b0;
            OVF   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (START_VALID) begin
                    a_r  <= A;
                    b_r  <= B;
                    cnt  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_r <= SUB;
                    cy_r  <= SUB ? 1'b1 : C;
`else
                    cy_r  <= C;
`endif
                end
                RUN: begin
                    SUM[cnt*DIGIT +: DIGIT] <= s_d;
                    cy_r <= cc[DIGIT];
                    cnt  <= cnt + 1'b1;
                    // Carry into the MSB is the ripple tap just below the top of the last digit.
                    if (last) begin
                        CARRY <= cc[DIGIT];
                        OVF   <= cc[DIGIT] ^ cc[DIGIT-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        START_READY = 1'b0;
        DONE_VALID  = 1'b0;
        case (state)
            IDLE: begin
                START_READY = RST_N;
                if (START_VALID) state_nx = RUN;
            end
            RUN:  if (last) state_nx = DONE;
            DONE: begin
                DONE_VALID = 1'b1;
                if (DONE_READY) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (W1/D1, W8/D1, W8/D4), directed vectors.
`timescale 1ns/1ps
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       sv1, sr1, a1, b1, c1, sub1, s1, co1, ov1, dv1, dr1;
    logic       sv8, sr8, c8, sub8, co8, ov8, dv8, dr8;
    logic [7:0] a8, b8, s8;
    logic       sv4, sr4, c4, sub4, co4, ov4, dv4, dr4;
    logic [7:0] a4, b4, s4;

    int n_chk  = 0;
    int n_fail = 0;
    logic [2:0] q1[$];
    logic [9:0] q8[$], q4[$];
    // {ovf, carry, sum} indexed by {a, b, c}
    logic [2:0] fa_tab [8] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b001, 3'b010, 3'b110, 3'b011};

    serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
        .CLK(clk), .RST_N(rst_n), .START_VALID(sv1), .START_READY(sr1), .A(a1), .B(b1), .C(c1),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub1),
`endif
        .SUM(s1), .CARRY(co1), .OVF(ov1), .DONE_VALID(dv1), .DONE_READY(dr1));

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .CLK(clk), .RST_N(rst_n), .START_VALID(sv8), .START_READY(sr8), .A(a8), .B(b8), .C(c8),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub8),
`endif
        .SUM(s8), .CARRY(co8), .OVF(ov8), .DONE_VALID(dv8), .DONE_READY(dr8));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
        .CLK(clk), .RST_N(rst_n), .START_VALID(sv4), .START_READY(sr4), .A(a4), .B(b4), .C(c4),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub4),
`endif
        .SUM(s4), .CARRY(co4), .OVF(ov4), .DONE_VALID(dv4), .DONE_READY(dr4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic sub, input logic sv);
        case (w)
            1: begin sv1 = sv; a1 = a[0]; b1 = b[0]; c1 = c; sub1 = sub; end
            8: begin sv8 = sv; a8 = a; b8 = b; c8 = c; sub8 = sub; end
            default: begin sv4 = sv; a4 = a; b4 = b; c4 = c; sub4 = sub; end
        endcase
    endtask

    function automatic logic get_sr(input int w);
        return (w == 1) ? sr1 : (w == 8) ? sr8 : sr4;
    endfunction

    function automatic logic get_dv(input int w);
        return (w == 1) ? dv1 : (w == 8) ? dv8 : dv4;
    endfunction

    function automatic logic [9:0] get_res(input int w);
        return (w == 1) ? {ov1, co1, 7'b0, s1} : (w == 8) ? {ov8, co8, s8} : {ov4, co4, s4};
    endfunction

    // Present operands, wait for accept, optionally check DONE_VALID latency. exp = {ovf, carry, sum}.
    task automatic issue(input string nm, input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic sub, input logic [9:0] exp, input int lat,
                         input bit push, input bit toggle, input bit wait_done);
        int cyc;
        @(negedge clk);
        drive(w, a, b, c, sub, 1'b1);
        cyc = 0;
        while (!get_sr(w) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!get_sr(w)) chk({nm, " accept timeout"}, cyc, 0);
        if (push) begin
            if (w == 1) q1.push_back({exp[9], exp[8], exp[0]});
            else if (w == 8) q8.push_back(exp);
            else q4.push_back(exp);
        end
        @(posedge clk);
        @(negedge clk);
        if (toggle) drive(w, ~a, ~b, ~c, sub, 1'b0);
        else drive(w, a, b, c, sub, 1'b0);
        if (!wait_done) return;
        cyc = 0;
        while (!get_dv(w) && cyc < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({nm, " latency"}, cyc, lat);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (dv1 && dr1) begin
                n_chk++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL u1 unexpected result: got %0h expected none", {ov1, co1, s1});
                end else chk("u1 result", {ov1, co1, s1}, q1.pop_front());
            end
            if (dv8 && dr8) begin
                n_chk++;
                if (q8.size() == 0) begin
                    n_fail++;
                    $display("FAIL u8 unexpected result: got %0h expected none", {ov8, co8, s8});
                end else chk("u8 result", {ov8, co8, s8}, q8.pop_front());
            end
            if (dv4 && dr4) begin
                n_chk++;
                if (q4.size() == 0) begin
                    n_fail++;
                    $display("FAIL u4 unexpected result: got %0h expected none", {ov4, co4, s4});
                end else chk("u4 result", {ov4, co4, s4}, q4.pop_front());
            end
        end
    endtask

    task automatic stim();
        logic [9:0] hold;
        rst_n = 1'b0;
        drive(1, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        drive(8, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        drive(4, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        dr1 = 1'b1; dr8 = 1'b1; dr4 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outputs u8", {dv8, get_res(8)}, 11'h0);
        chk("reset outputs u4", {dv4, get_res(4)}, 11'h0);
        chk("ready in reset", {sr1, sr8, sr4}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", {sr1, sr8, sr4}, 3'b111);

        for (int i = 0; i < 8; i++)
            issue("fa", 1, {7'b0, i[2]}, {7'b0, i[1]}, i[0], 1'b0,
                  {fa_tab[i][2], fa_tab[i][1], 7'b0, fa_tab[i][0]}, 1, 1, 0, 1);

        issue("ff+01", 8, 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, 8, 1, 0, 1);
        issue("7f+01", 8, 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}, 8, 1, 0, 1);
        issue("3c+55+1", 4, 8'h3C, 8'h55, 1'b1, 1'b0, {1'b1, 1'b0, 8'h92}, 2, 1, 1, 1);
        issue("f0+10", 4, 8'hF0, 8'h10, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, 2, 1, 1, 1);

        // Backpressure on the 8-cycle instance; a START pulse during DONE must be dropped.
        @(posedge clk);
        #1 dr8 = 1'b0;
        issue("bp", 8, 8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10}, 8, 1, 0, 1);
        hold = get_res(8);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(8, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
            else drive(8, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("bp valid held", dv8, 1'b1);
            chk("bp result stable", get_res(8), hold);
            chk("bp start_ready low", sr8, 1'b0);
        end
        @(posedge clk);
        #1 dr8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp ready after handshake", sr8, 1'b1);

        // Abort on the 3rd RUN edge.
        issue("abort", 8, 8'h12, 8'h34, 1'b0, 1'b0, 10'h0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort cleared", {dv8, get_res(8)}, 11'h0);
        chk("abort ready in reset", sr8, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort ready after release", sr8, 1'b1);
        issue("12+34", 8, 8'h12, 8'h34, 1'b0, 1'b0, {1'b0, 1'b0, 8'h46}, 8, 1, 0, 1);

`ifdef SERIAL_ADDER_SUB_EN
        issue("05-07", 8, 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}, 8, 1, 0, 1);
        issue("80-01", 8, 8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h7F}, 8, 1, 0, 1);
        issue("sub4 05-07", 4, 8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE}, 2, 1, 1, 1);
`endif

        repeat (4) @(negedge clk);
        chk("q1 drained", q1.size(), 0);
        chk("q8 drained", q8.size(), 0);
        chk("q4 drained", q4.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stim();
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
